calc_display: RTL

- Downstream stage of the calculator core. Consumes the serial digit stream (data, pos, status) and drives an 8-digit multiplexed common-anode seven-segment display.
- Assembles each 8-digit print frame into a shadow buffer. Commits the frame atomically to the live buffer, so the display never shows a half-written number.
- Overrides the display with busy and error patterns taken from status.

---
 rtl/calc_display_if.sv | 14 +
 rtl/calc_display.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/calc_display_if.sv
// Core-to-display link for calc_display: serial digit stream in, multiplexed
// seven-segment drive out.
interface calc_display_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (output status, data, pos, input an, seg, dp, frame_done);
    modport slave  (input status, data, pos, output an, seg, dp, frame_done);
endinterface

// File: rtl/calc_display.sv
// 8-digit seven-segment display stage: shadow/live frame buffering, status overrides, scan.
// Optional leading-zero blanking is enabled with `define CALC_DISPLAY_LZB_EN.
module calc_display #(
    parameter int DIV_W = 16
) (
    input logic           clock,
    input logic           reset,
    calc_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t            state_q, state_d;
    logic [1:0]        status_q;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        idx_q;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic [7:0][3:0]   shadow_q, live_q;
    logic [7:0]        show;
    logic [6:0]        pat;
    logic              tick, printing, wr_en;
    logic [2:0]        wr_idx;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = SEG_BLANK;
        endcase
    endfunction

    assign tick     = &div_q;
    assign printing = (bus.status == 2'b11);
    // pos==k carries digit k-1; pos==8 wraps to index 7 in three bits
    assign wr_idx   = bus.pos[2:0] - 3'd1;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (printing && bus.pos == 4'd1) begin
                wr_en   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!printing || bus.pos == 4'd0 || bus.pos > 4'd8) begin
                    state_d = IDLE;
                end else if (bus.pos >= 4'd2) begin
                    wr_en = 1'b1;
                    if (bus.pos == 4'd8) state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            status_q <= 2'b10;
            shadow_q <= '0;
            live_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= bus.status;
            if (wr_en) shadow_q[wr_idx] <= bus.data;
            if (state_q == COMMIT) live_q <= shadow_q;
        end
    end

`ifdef CALC_DISPLAY_LZB_EN
    logic [7:0] show_q, show_d;
    logic       nz_above;

    // Visibility is derived from the frame being committed so it lands with live_q
    always_comb begin
        show_d    = 8'h01;
        nz_above  = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            nz_above  = nz_above | (shadow_q[k] != 4'd0);
            show_d[k] = nz_above;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 show_q <= 8'h01;
        else if (state_q == COMMIT) show_q <= show_d;
    end

    assign show = show_q;
`else
    assign show = 8'hFF;
`endif

    always_comb begin
        pat = SEG_BLANK;
        case (status_q)
            2'b00: case (idx_q)
                3'd3:       pat = 7'b0000110;
                3'd2, 3'd1: pat = 7'b0101111;
                3'd0:       pat = 7'b0100011;
                default:    pat = SEG_BLANK;
            endcase
            2'b01:   pat = 7'b0111111;
            default: pat = show[idx_q] ? dec(live_q[idx_q]) : SEG_BLANK;
        endcase
    end

    // an and seg load together on a tick so a digit never shows its neighbour's segments
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            idx_q <= 3'd0;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else begin
            div_q <= div_q + 1'b1;
            if (tick) begin
                an_q  <= ~(8'd1 << idx_q);
                seg_q <= pat;
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = (state_q == COMMIT);
endmodule
